// File: rtl/fp16_to_fp32_arb_pkg.sv
// Shared types for the fp16->fp32 chn_o output arbiter.
package fp16_to_fp32_arb_pkg;

    localparam int unsigned ARB_DATA_W = 32;
    localparam int unsigned ARB_ID_W   = 2;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    // One output beat: payload, source lane and end-of-burst marker
    typedef struct packed {
        logic [ARB_DATA_W-1:0] pd;
        logic [ARB_ID_W-1:0]   id;
        logic                  last;
    } beat_t;

endpackage

// File: rtl/fp16_to_fp32_chn_o_skid.sv
// Two-entry skid buffer carrying beats towards the chn_o consumer (lz = valid, vz = ready).
module fp16_to_fp32_chn_o_skid
    import fp16_to_fp32_arb_pkg::*;
#(
    parameter type T = beat_t
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  T           i_beat,
    output logic [1:0] o_count,
    output T           o_beat,
    output logic       o_lz,
    input  logic       i_vz
);

    T           r_mem [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign w_pop  = (r_count != 2'd0) & i_vz;
    assign w_push = i_push & (r_count != 2'd2);

    // Storage, pointers and occupancy; reset clears payload so z reads 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_beat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_beat  = r_mem[r_rd_ptr];
    assign o_lz    = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/fp16_to_fp32_chn_o_arb.sv
// Burst-locking round-robin arbiter sharing the fp16->fp32 chn_o output among NUM_REQ lanes.
module fp16_to_fp32_chn_o_arb
    import fp16_to_fp32_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned DATA_W    = ARB_DATA_W,
    parameter  int unsigned MAX_BURST = 16,
    localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rst,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ*DATA_W-1:0] req_pd,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic [DATA_W-1:0]         chn_o_rsc_z,
    output logic [ID_W-1:0]           chn_o_rsc_id,
    output logic                      chn_o_rsc_last,
    output logic                      chn_o_rsc_lz,
    input  logic                      chn_o_rsc_vz,
    output logic                      arb_busy,
    output logic                      burst_ovf
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef struct packed {
        logic [DATA_W-1:0] pd;
        logic [ID_W-1:0]   id;
        logic              last;
    } lane_beat_t;

    arb_state_e         r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_owner;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_arb_busy;
    logic               r_burst_ovf;

    logic [1:0]         w_count;
    logic               w_space;
    logic [ID_W-1:0]    w_grant;
    logic [NUM_REQ-1:0] w_rdy;
    logic               w_accept;
    logic               w_acc_last;
    lane_beat_t         w_push_beat;
    lane_beat_t         w_out_beat;

    // First valid lane at or after ptr, wrapping NUM_REQ-1 -> 0
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        logic            found;
        int unsigned     idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (k + {{(32-ID_W){1'b0}}, ptr}) % NUM_REQ;
            if (!found && vld[idx]) begin
                found = 1'b1;
                pick  = idx[ID_W-1:0];
            end
        end
        return pick;
    endfunction

    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] g);
        if ({{(32-ID_W){1'b0}}, g} == NUM_REQ - 1) begin
            return '0;
        end
        return g + ID_W'(1);
    endfunction

    // Space depends only on registered occupancy, never on chn_o_rsc_vz
    assign w_space = (w_count != 2'd2);

    // Grant selection: owner while locked, round-robin pick while idle
    always_comb begin
        w_rdy   = '0;
        w_grant = r_rr_ptr;
        if (r_state == ARB_LOCKED) begin
            w_grant = r_owner;
        end else if (|req_vld) begin
            w_grant = rr_pick(req_vld, r_rr_ptr);
        end
        if (!nvdla_core_rst && w_space && ((r_state == ARB_LOCKED) || (|req_vld))) begin
            w_rdy[w_grant] = 1'b1;
        end
    end

    assign w_accept    = |(req_vld & w_rdy);
    assign w_acc_last  = req_last[w_grant];
    assign w_push_beat = {req_pd[w_grant*DATA_W +: DATA_W], w_grant, w_acc_last};

    // Lock state machine, round-robin pointer, burst counter and sticky overflow flag
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_beat_cnt  <= '0;
            r_arb_busy  <= 1'b0;
            r_burst_ovf <= 1'b0;
        end else if (w_accept) begin
            if (r_state == ARB_IDLE) begin
                if (w_acc_last) begin
                    r_rr_ptr <= rr_next(w_grant);
                end else begin
                    r_state    <= ARB_LOCKED;
                    r_owner    <= w_grant;
                    r_beat_cnt <= CNT_W'(1);
                    r_arb_busy <= 1'b1;
                end
            end else begin
                if (w_acc_last) begin
                    r_state    <= ARB_IDLE;
                    r_rr_ptr   <= rr_next(r_owner);
                    r_arb_busy <= 1'b0;
                end else if (r_beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                    r_state     <= ARB_IDLE;
                    r_rr_ptr    <= rr_next(r_owner);
                    r_arb_busy  <= 1'b0;
                    r_burst_ovf <= 1'b1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                end
            end
        end
    end

    fp16_to_fp32_chn_o_skid #(
        .T (lane_beat_t)
    ) u_skid (
        .i_clk   (nvdla_core_clk),
        .i_rst   (nvdla_core_rst),
        .i_push  (w_accept),
        .i_beat  (w_push_beat),
        .o_count (w_count),
        .o_beat  (w_out_beat),
        .o_lz    (chn_o_rsc_lz),
        .i_vz    (chn_o_rsc_vz)
    );

    assign req_rdy        = w_rdy;
    assign chn_o_rsc_z    = w_out_beat.pd;
    assign chn_o_rsc_id   = w_out_beat.id;
    assign chn_o_rsc_last = w_out_beat.last;
    assign arb_busy       = r_arb_busy;
    assign burst_ovf      = r_burst_ovf;

endmodule
